// File: rtl/core_pkg.sv
// Shared scalar-core widths and the ID/EX payload layout.
package core_pkg;

  localparam int REGISTERS = 32;
  localparam int REG_AW    = $clog2(REGISTERS);
  localparam int XLEN      = 32;
  localparam int CTRL_W    = 16;
  localparam int NUM_SRC   = 2;

  // Everything the ID/EX register carries apart from its valid bit.
  typedef struct packed {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [REG_AW-1:0] a3;
    logic              we;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

endpackage

// File: rtl/decode_execute_stage_if.sv
// Decode-side, forwarding-side and execute-side signals of the ID/EX stage.
interface decode_execute_stage_if;
  import core_pkg::*;

  logic              flush;
  // decode side
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_a1, in_a2, in_a3;
  logic              in_use1, in_use2;
  logic [XLEN-1:0]   in_rd1, in_rd2;
  logic              in_we, in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  // in-flight producers
  logic              mem_we, mem_is_load;
  logic [REG_AW-1:0] mem_a3;
  logic [XLEN-1:0]   mem_wd;
  logic              wb_we;
  logic [REG_AW-1:0] wb_a3;
  logic [XLEN-1:0]   wb_wd;
  // execute side
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_op1, out_op2;
  logic [REG_AW-1:0] out_a3;
  logic              out_we, out_is_load;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       stall_cnt;

  modport master (
    output flush, in_valid, in_a1, in_a2, in_a3, in_use1, in_use2,
           in_rd1, in_rd2, in_we, in_is_load, in_ctrl,
           mem_we, mem_is_load, mem_a3, mem_wd, wb_we, wb_a3, wb_wd, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_a3, out_we,
           out_is_load, out_ctrl, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_a1, in_a2, in_a3, in_use1, in_use2,
           in_rd1, in_rd2, in_we, in_is_load, in_ctrl,
           mem_we, mem_is_load, mem_a3, mem_wd, wb_we, wb_a3, wb_wd, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_a3, out_we,
           out_is_load, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_bypass.sv
// One source operand: x0, then MEM result, then WB result, then register file.
module operand_bypass
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] a,
  input  logic [XLEN-1:0]   rf,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_a3,
  input  logic [XLEN-1:0]   mem_wd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_a3,
  input  logic [XLEN-1:0]   wb_wd,
  output logic [XLEN-1:0]   op
);

  // MEM is younger than WB, so it must win when both target the same register.
  always_comb begin
    op = rf;
    if (a == '0)                      op = '0;
    else if (mem_we && mem_a3 == a)   op = mem_wd;
    else if (wb_we && wb_a3 == a)     op = wb_wd;
  end

endmodule

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register: operand bypass, load-use hazard stall, bubble insertion.
module decode_execute_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  decode_execute_stage_if.slave bus
);

  logic [NUM_SRC-1:0][REG_AW-1:0] src_a;
  logic [NUM_SRC-1:0][XLEN-1:0]   src_rf;
  logic [NUM_SRC-1:0][XLEN-1:0]   src_op;
  logic [NUM_SRC-1:0]             src_use;
  logic [NUM_SRC-1:0]             src_haz;

  logic   hazard, accept, count_en;
  logic   vld_q;
  id_ex_t q, d;

  assign src_a   = {bus.in_a2,   bus.in_a1};
  assign src_rf  = {bus.in_rd2,  bus.in_rd1};
  assign src_use = {bus.in_use2, bus.in_use1};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    operand_bypass u_byp (
      .a      (src_a[i]),
      .rf     (src_rf[i]),
      .mem_we (bus.mem_we),
      .mem_a3 (bus.mem_a3),
      .mem_wd (bus.mem_wd),
      .wb_we  (bus.wb_we),
      .wb_a3  (bus.wb_a3),
      .wb_wd  (bus.wb_wd),
      .op     (src_op[i])
    );

    // A load's data is not ready until after MEM, so a consumer in ID/EX or MEM
    // distance of that load must wait; WB distance is covered by the bypass.
    assign src_haz[i] = src_use[i] && (src_a[i] != '0) &&
                        ((vld_q && q.is_load && q.we && q.a3 == src_a[i]) ||
                         (bus.mem_is_load && bus.mem_we && bus.mem_a3 == src_a[i]));
  end

  assign hazard   = |src_haz;
  assign accept   = bus.in_valid && bus.in_ready;
  assign count_en = bus.in_valid && hazard && !bus.flush;

  assign bus.in_ready = !bus.flush && !hazard && (!vld_q || bus.out_ready);

  always_comb begin
    d         = '0;
    d.op1     = src_op[0];
    d.op2     = src_op[1];
    d.a3      = bus.in_a3;
    d.we      = bus.in_we;
    d.is_load = bus.in_is_load;
    d.ctrl    = bus.in_ctrl;
  end

  // Pipeline register: flush kills, accept loads, consume without accept bubbles,
  // otherwise hold (operands are not re-resolved while held).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      q     <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      q     <= d;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Load-use stall counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                   bus.stall_cnt <= '0;
    else if (count_en && bus.stall_cnt != '1)  bus.stall_cnt <= bus.stall_cnt + 32'd1;
  end

  assign bus.out_valid   = vld_q;
  assign bus.out_op1     = q.op1;
  assign bus.out_op2     = q.op2;
  assign bus.out_a3      = q.a3;
  assign bus.out_we      = q.we;
  assign bus.out_is_load = q.is_load;
  assign bus.out_ctrl    = q.ctrl;

endmodule
